rtc_port_regbank: RTL and testbench
===================================

// Module: rtc_port_regbank
// PURPOSE
//  Clocked, parametrised PicoBlaze port-mapped register bank between the soft CPU and the RTC read/write engine.
//  - Holds NREG write-shadow fields (date/time/timer) and a field-select decoder.
//  - Muxes NREG RTC read-back fields onto in_port.
//  - Adds a commit handshake to the RTC writer, with timeout, and a sticky status register.
// PARAMETERS
//  NREG        9       number of time fields (shadow and read-back)
//  DW          8       field / data-bus width (must be >= 4)
//  SEL_PORT    8'h01   field-select register port
//  WR_BASE     8'h02   first shadow-write port (WR_BASE..WR_BASE+NREG-1)
//  CMD_PORT    8'h0B   ht_ready control port
//  STAT_PORT   8'h0C   status read port
//  RD_BASE     8'h0D   first read-back port (RD_BASE..RD_BASE+NREG-1)
//  TIMER_PORT  8'h16   timer-modify command port
//  COMMIT_PORT 8'h17   commit-start port
//  TIMEOUT     1000    max cycles to wait for commit_ack
// PORTS
//  clk           in   1        system clock
//  reset         in   1        reset, synchronous, active-high
//  write_strobe  in   1        PicoBlaze OUTPUT strobe
//  read_strobe   in   1        PicoBlaze INPUT strobe
//  port_id       in   8        PicoBlaze port address
//  out_port      in   DW       PicoBlaze write data
//  in_port       out  DW       PicoBlaze read data (registered)
//  wr_data       out  NREG*DW  shadow fields; field i = wr_data[i*DW +: DW]
//  rd_data       in   NREG*DW  RTC read-back fields, same packing
//  sel_onehot    out  NREG     one-hot field enable to the RTC writer
//  commit_req    out  1        request: RTC writer must load wr_data
//  commit_ack    in   1        RTC writer done (single-cycle pulse or level)
//  timer_mod     out  1        one-cycle pulse: timer modify command
//  ht_ready      out  1        timer-setting-complete level
// BEHAVIOUR
//  Reset state:
//   - wr_data=0, sel reg=NREG (sel_onehot=0), in_port=0.
//   - commit_req=0, timer_mod=0, ht_ready=0, done=0, err=0, FSM=IDLE, timeout counter=0.
//  Writes: all take effect at the clk edge where write_strobe=1 and port_id matches.
//   - SEL_PORT: sel<=out_port. sel_onehot[v]=1 when v<NREG; otherwise all zero.
//   - WR_BASE+i: field i<=out_port. Ignored while FSM!=IDLE (data stays stable during handshake).
//   - CMD_PORT: ht_ready<=(out_port==1).
//   - TIMER_PORT: timer_mod=1 for exactly the next cycle iff out_port==9; else stays 0.
//   - COMMIT_PORT: any data; IDLE->REQ. Ignored when not IDLE.
//  Reads: in_port registered, 1-cycle latency after port_id changes, independent of read_strobe.
//   - RD_BASE+i -> rd_data field i.
//   - STAT_PORT -> {0..,err,ht_ready,done,busy}, busy=(FSM!=IDLE).
//   - Any unmapped port -> 0.
//  Commit FSM, states IDLE / REQ / DONE:
//   - IDLE: commit_req=0.
//   - REQ: commit_req=1; counter increments each cycle.
//     - commit_ack=1 -> DONE.
//     - counter reaches TIMEOUT-1 with no ack -> IDLE, err<=1.
//     - ack on the same cycle as expiry -> ack wins (DONE, no err).
//   - DONE: commit_req=0, done<=1, counter cleared, -> IDLE next cycle.
//   - Minimum commit latency: REQ asserted 1 cycle after the write; IDLE 2 cycles after ack.
//   - commit_ack while IDLE or DONE: ignored.
//  Status flags:
//   - done and err are sticky.
//   - Cleared by read_strobe=1 with port_id==STAT_PORT; the cleared value is visible on the next read.
//   - A set condition on the same cycle as a clear wins (flag stays 1).
//  Port map: overlapping address ranges are an integration error; first match order is SEL, WR, CMD, TIMER, COMMIT.
//  Reset mid-commit: FSM->IDLE and commit_req drops on the reset edge; no flag is set.
// TESTING
//  1 Reset, then read STAT_PORT -> in_port=0x00; sel_onehot=0; wr_data=0.
//  2 Write SEL_PORT=3 -> sel_onehot=9'b000001000. Write SEL_PORT=9 or 0x20 -> sel_onehot=0.
//  3 Write WR_BASE+2=0x15, then COMMIT. Ack 4 cycles later -> commit_req high 4 cycles; status reads 0x02 (done).
//    Second status read -> 0x00.
//  4 During REQ, write WR_BASE+2=0x99 -> field 2 stays 0x15. Second COMMIT write ignored.
//  5 COMMIT with no ack -> commit_req drops after TIMEOUT cycles; status=0x08.
//    Ack on the exact expiry cycle -> status=0x02.
//  6 TIMER_PORT=9 -> timer_mod one-cycle pulse; TIMER_PORT=8 -> none.
//    CMD_PORT=1 -> ht_ready=1 and status bit2=1; CMD_PORT=0 -> ht_ready=0.

Source files
------------

// File: rtl/rtc_port_regbank.sv
// rtl/rtc_port_regbank.sv - PicoBlaze port-mapped register bank with RTC commit handshake
module rtc_port_regbank #(
    parameter int         NREG        = 9,
    parameter int         DW          = 8,
    parameter logic [7:0] SEL_PORT    = 8'h01,
    parameter logic [7:0] WR_BASE     = 8'h02,
    parameter logic [7:0] CMD_PORT    = 8'h0B,
    parameter logic [7:0] STAT_PORT   = 8'h0C,
    parameter logic [7:0] RD_BASE     = 8'h0D,
    parameter logic [7:0] TIMER_PORT  = 8'h16,
    parameter logic [7:0] COMMIT_PORT = 8'h17,
    parameter int         TIMEOUT     = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    input  logic [7:0]           port_id,
    input  logic [DW-1:0]        out_port,
    output logic [DW-1:0]        in_port,
    output logic [NREG*DW-1:0]   wr_data,
    input  logic [NREG*DW-1:0]   rd_data,
    output logic [NREG-1:0]      sel_onehot,
    output logic                 commit_req,
    input  logic                 commit_ack,
    output logic                 timer_mod,
    output logic                 ht_ready
);
    localparam int         CW    = $clog2(TIMEOUT + 1);
    localparam logic [7:0] NREG8 = 8'(NREG);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state;
    logic [DW-1:0]   sel;
    logic [CW-1:0]   cnt;
    logic            done, err;
    logic [7:0]      wr_off, rd_off;
    logic            is_sel, in_wr, is_cmd, is_timer, is_commit;
    logic            sel_hit, wr_hit, cmd_hit, timer_hit, commit_hit;
    logic            stat_clr, done_set, err_set, expired;
    logic [DW-1:0]   rd_val;

    // Decode follows the fixed priority SEL, WR, CMD, TIMER, COMMIT so overlaps resolve deterministically
    always_comb begin
        wr_off     = port_id - WR_BASE;
        rd_off     = port_id - RD_BASE;
        is_sel     = (port_id == SEL_PORT);
        in_wr      = !is_sel && (wr_off < NREG8);
        is_cmd     = !is_sel && !in_wr && (port_id == CMD_PORT);
        is_timer   = !is_sel && !in_wr && !is_cmd && (port_id == TIMER_PORT);
        is_commit  = !is_sel && !in_wr && !is_cmd && !is_timer && (port_id == COMMIT_PORT);
        sel_hit    = write_strobe && is_sel;
        wr_hit     = write_strobe && in_wr;
        cmd_hit    = write_strobe && is_cmd;
        timer_hit  = write_strobe && is_timer;
        commit_hit = write_strobe && is_commit;
        stat_clr   = read_strobe && (port_id == STAT_PORT);
        expired    = (cnt == CW'(TIMEOUT - 1));
        done_set   = (state == DONE);
        err_set    = (state == REQ) && !commit_ack && expired;
    end

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NREG; i++)
            if (sel == DW'(i)) sel_onehot[i] = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        if (port_id == STAT_PORT) begin
            rd_val[3:0] = {err, ht_ready, done, state != IDLE};
        end else begin
            for (int i = 0; i < NREG; i++)
                if (rd_off == 8'(i)) rd_val = rd_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel        <= DW'(NREG);
            wr_data    <= '0;
            in_port    <= '0;
            ht_ready   <= 1'b0;
            timer_mod  <= 1'b0;
            commit_req <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
        end else begin
            if (sel_hit) sel <= out_port;
            for (int i = 0; i < NREG; i++)
                if (wr_hit && state == IDLE && wr_off == 8'(i))
                    wr_data[i*DW +: DW] <= out_port;
            if (cmd_hit) ht_ready <= (out_port == DW'(1));
            timer_mod <= timer_hit && (out_port == DW'(9));
            in_port   <= rd_val;

            // Set beats clear when both land on the same cycle
            if (done_set)      done <= 1'b1;
            else if (stat_clr) done <= 1'b0;
            if (err_set)       err  <= 1'b1;
            else if (stat_clr) err  <= 1'b0;

            case (state)
                IDLE: if (commit_hit) begin
                    state      <= REQ;
                    commit_req <= 1'b1;
                    cnt        <= '0;
                end
                REQ: begin
                    if (commit_ack) begin
                        state      <= DONE;
                        commit_req <= 1'b0;
                        cnt        <= '0;
                    end else if (expired) begin
                        state      <= IDLE;
                        commit_req <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rtc_port_regbank.sv
// tb/tb_rtc_port_regbank.sv - scoreboard bench for rtc_port_regbank
module tb_rtc_port_regbank;
    logic        clk = 1'b0;
    logic        reset;
    logic        write_strobe, read_strobe, commit_ack;
    logic [7:0]  port_id, out_port, in_port;
    logic [71:0] wr_data, rd_data;
    logic [8:0]  sel_onehot;
    logic        commit_req, timer_mod, ht_ready;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      req_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    logic    rs_d    = 1'b0;
    int      req_run = 0;

    rtc_port_regbank dut (
        .clk(clk), .reset(reset), .write_strobe(write_strobe), .read_strobe(read_strobe),
        .port_id(port_id), .out_port(out_port), .in_port(in_port), .wr_data(wr_data),
        .rd_data(rd_data), .sel_onehot(sel_onehot), .commit_req(commit_req),
        .commit_ack(commit_ack), .timer_mod(timer_mod), .ht_ready(ht_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Read data is valid the cycle after a strobed read; commit pulses are measured on their falling edge
    always @(posedge clk) rs_d <= read_strobe;

    always @(negedge clk) begin
        if (rs_d) begin
            if (rd_q.size() == 0) chk("rd_q_underflow", 1, 0);
            else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk(e.name, in_port, e.exp);
            end
        end
        if (commit_req) req_run++;
        else if (req_run > 0) begin
            if (req_q.size() == 0) chk("req_q_underflow", req_run, 0);
            else chk("commit_req_len", req_run, req_q.pop_front());
            req_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic rd(input logic [7:0] p, input logic [7:0] exp, input string nm);
        rd_exp_t e;
        e.name = nm; e.exp = exp;
        rd_q.push_back(e);
        port_id = p; read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0; port_id = 8'h00;
    endtask

    initial begin
        reset = 1'b1; write_strobe = 1'b0; read_strobe = 1'b0; commit_ack = 1'b0;
        port_id = 8'h00; out_port = 8'h00;
        for (int i = 0; i < 9; i++) rd_data[i*8 +: 8] = 8'hA0 + 8'(i);
        tick(); tick();
        chk("rst_sel_onehot", sel_onehot, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_in_port", in_port, 0);
        chk("rst_commit_req", commit_req, 0);
        chk("rst_timer_mod", timer_mod, 0);
        chk("rst_ht_ready", ht_ready, 0);
        reset = 1'b0;
        rd(8'h0C, 8'h00, "rst_status");

        wr(8'h01, 8'd3);   chk("sel_3", sel_onehot, 9'b000001000);
        wr(8'h01, 8'd8);   chk("sel_8", sel_onehot, 9'b100000000);
        wr(8'h01, 8'd9);   chk("sel_9", sel_onehot, 0);
        wr(8'h01, 8'h20);  chk("sel_20", sel_onehot, 0);

        rd(8'h0D, 8'hA0, "rd_field0");
        rd(8'h15, 8'hA8, "rd_field8");
        rd(8'h30, 8'h00, "rd_unmapped");
        rd(8'h01, 8'h00, "rd_sel_port");

        // Commit with ack on the 4th request cycle; shadow writes and re-commit ignored meanwhile
        wr(8'h04, 8'h15);
        chk("field2_written", wr_data[23:16], 8'h15);
        req_q.push_back(4);
        wr(8'h17, 8'h00);
        chk("req_asserted", commit_req, 1);
        wr(8'h04, 8'h99);
        wr(8'h17, 8'h00);
        tick();
        commit_ack = 1'b1; tick(); commit_ack = 1'b0;
        chk("req_dropped", commit_req, 0);
        chk("field2_stable", wr_data[23:16], 8'h15);
        tick();
        rd(8'h0C, 8'h02, "status_done");
        rd(8'h0C, 8'h00, "status_cleared");

        commit_ack = 1'b1; tick(); commit_ack = 1'b0;
        rd(8'h0C, 8'h00, "ack_idle_ignored");

        // Timeout without ack
        req_q.push_back(1000);
        wr(8'h17, 8'h00);
        repeat (1002) tick();
        chk("timeout_req_low", commit_req, 0);
        rd(8'h0C, 8'h08, "status_err");
        rd(8'h0C, 8'h00, "status_err_cleared");

        // Ack exactly on the expiry cycle
        req_q.push_back(1000);
        wr(8'h17, 8'h00);
        repeat (999) tick();
        commit_ack = 1'b1; tick(); commit_ack = 1'b0;
        tick();
        rd(8'h0C, 8'h02, "status_ack_at_expiry");
        rd(8'h0C, 8'h00, "status_expiry_cleared");

        wr(8'h16, 8'd9);  chk("timer_pulse", timer_mod, 1);
        tick();           chk("timer_pulse_end", timer_mod, 0);
        wr(8'h16, 8'd8);  chk("timer_no_pulse", timer_mod, 0);
        wr(8'h0B, 8'd1);  chk("ht_ready_set", ht_ready, 1);
        rd(8'h0C, 8'h04, "status_ht_ready");
        wr(8'h0B, 8'd0);  chk("ht_ready_clr", ht_ready, 0);

        // Reset in the middle of a commit
        req_q.push_back(3);
        wr(8'h17, 8'h00);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_reset_req", commit_req, 0);
        chk("mid_reset_wr_data", wr_data, 0);
        rd(8'h0C, 8'h00, "status_after_reset");

        tick(); tick();
        chk("rd_q_empty", rd_q.size(), 0);
        chk("req_q_empty", req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
